// File: rtl/spi_target_sync_pkg.sv
// Shared definitions for the clk-domain SPI target: FSM encodings and SPI mode constants.
package spi_target_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic CKP_IDLE_LOW  = 1'b0;
  localparam logic CKP_IDLE_HIGH = 1'b1;
  localparam logic CPH_LEADING   = 1'b0;
  localparam logic CPH_TRAILING  = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by one edge-detect register; level is the synchronized value.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/spi_target_sync.sv
// SPI target running on the system clock: oversamples SCK/SS/MOSI, decodes CKP/CPH,
// deserializes MOSI into rx_data and serializes the transmit hold register onto MISO.
module spi_target_sync
  import spi_target_sync_pkg::*;
#(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] IDLE_TX = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCK,
  input  logic              SS,
  input  logic              MOSI,
  input  logic              CKP,
  input  logic              CPH,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output state_t            dbg_state
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  logic sck_level_unused, sck_rise, sck_fall;
  logic ss_level, ss_rise_s, ss_fall_s;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .din(SCK),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  // SS idles high, so it resets high to avoid a false select right after reset.
  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .din(SS),
    .level(ss_level), .rise(ss_rise_s), .fall(ss_fall_s)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(MOSI),
    .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t            state;
  logic              ckp_r, cph_r;
  logic [DATA_W-1:0] hold, hold_eff;
  logic [DATA_W-1:0] shift_tx, shift_rx;
  logic [CW-1:0]     bit_cnt;
  logic              loaded_mid;
  logic              lead_edge, trail_edge, sample_edge, shift_edge;

  assign lead_edge   = (ckp_r == CKP_IDLE_HIGH) ? sck_fall : sck_rise;
  assign trail_edge  = (ckp_r == CKP_IDLE_HIGH) ? sck_rise : sck_fall;
  assign sample_edge = (cph_r == CPH_LEADING) ? lead_edge : trail_edge;
  assign shift_edge  = (cph_r == CPH_LEADING) ? trail_edge : lead_edge;

  // tx_load/tx_ready: a tx_load strobe always writes the hold register and drops tx_ready;
  // tx_ready rises again once a word built from that value has completed. A strobe in the
  // cycle a word starts is written through into that word.
  always_comb begin
    hold_eff = hold;
    if (tx_load) hold_eff = tx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      MISO       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      tx_ready   <= 1'b1;
      hold       <= IDLE_TX;
      shift_tx   <= '0;
      shift_rx   <= '0;
      bit_cnt    <= '0;
      ckp_r      <= CKP_IDLE_LOW;
      cph_r      <= CPH_LEADING;
      loaded_mid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      busy     <= ~ss_level;
      case (state)
        ST_IDLE: begin
          ckp_r   <= CKP;
          cph_r   <= CPH;
          bit_cnt <= '0;
          MISO    <= 1'b0;
          if (ss_fall_s) begin
            state      <= ST_SHIFT;
            shift_tx   <= hold_eff;
            tx_ready   <= 1'b0;
            loaded_mid <= 1'b0;
            MISO       <= (CPH == CPH_LEADING) ? hold_eff[DATA_W-1] : 1'b0;
          end
        end
        ST_SHIFT: begin
          if (ss_rise_s) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            MISO    <= 1'b0;
          end else begin
            if (tx_load) loaded_mid <= 1'b1;
            if (sample_edge) begin
              shift_rx <= {shift_rx[DATA_W-2:0], mosi_level};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_LAST) state <= ST_DONE;
            end else if (shift_edge) begin
              // CPH=0 already shows the MSB at select; its trailing edge after the
              // final sample (bit_cnt back at 0) belongs to the finished word.
              if (cph_r == CPH_TRAILING) begin
                MISO     <= shift_tx[DATA_W-1];
                shift_tx <= {shift_tx[DATA_W-2:0], 1'b0};
              end else if (bit_cnt != '0) begin
                MISO     <= shift_tx[DATA_W-2];
                shift_tx <= {shift_tx[DATA_W-2:0], 1'b0};
              end
            end
          end
        end
        ST_DONE: begin
          bit_cnt    <= '0;
          loaded_mid <= 1'b0;
          if (ss_rise_s) begin
            state <= ST_IDLE;
            MISO  <= 1'b0;
          end else begin
            rx_data  <= shift_rx;
            rx_valid <= 1'b1;
            shift_tx <= hold_eff;
            tx_ready <= ~loaded_mid;
            if (!ss_level) begin
              state <= ST_SHIFT;
              MISO  <= (cph_r == CPH_LEADING) ? hold_eff[DATA_W-1] : 1'b0;
            end else begin
              state <= ST_IDLE;
              MISO  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          MISO  <= 1'b0;
        end
      endcase
      if (tx_load) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end
    end
  end

  assign dbg_state = state;

endmodule
